// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
//   muldiv_op_e    : funct3 encodings of the M-extension operations
//   muldiv_state_e : control FSM states
//   MULDIV_ITERS   : radix-2 iterations per normal operation
package muldiv_pkg;

  localparam int unsigned MULDIV_ITERS = 32;
  localparam int unsigned MULDIV_CNT_W = 5;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } muldiv_state_e;

  function automatic logic op_is_div(muldiv_op_e op);
    return (op inside {OpDiv, OpDivu, OpRem, OpRemu});
  endfunction

  // Operand a is treated as signed (converted to magnitude before iterating).
  function automatic logic op_a_signed(muldiv_op_e op);
    return (op inside {OpMulh, OpMulhsu, OpDiv, OpRem});
  endfunction

  // Operand b is signed; MULHSU deliberately excluded.
  function automatic logic op_b_signed(muldiv_op_e op);
    return (op inside {OpMulh, OpDiv, OpRem});
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: shift-add multiply / restoring divide on operand magnitudes,
// one radix-2 step per i_step, with sign fix-up applied on the final step.
// Ports:
//   clk, rst         : clock, async active-high reset
//   i_load           : latch op and operands, clear the accumulator
//   i_step           : perform one iteration
//   i_finish         : with i_step, register the signed final result
//   i_special        : with i_load, register i_special_res directly
//   i_op, i_a, i_b   : operation and operands
//   o_result         : registered result
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_finish,
  input  logic                  i_special,
  input  logic [DATA_WIDTH-1:0] i_special_res,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int unsigned W = DATA_WIDTH;

  muldiv_op_e     w_op;
  muldiv_op_e     r_op;
  logic           w_sa, w_sb;
  logic [W-1:0]   w_mag_a, w_mag_b;
  logic [W-1:0]   r_hi, r_lo, r_b, r_result;
  logic           r_neg_main, r_neg_rem;
  logic [W:0]     w_sum, w_shift, w_diff;
  logic [W-1:0]   w_hi_n, w_lo_n, w_quo, w_rem, w_final;
  logic [2*W-1:0] w_prod, w_prod_s;

  assign w_op    = muldiv_op_e'(i_op);
  assign w_sa    = op_a_signed(w_op) & i_a[W-1];
  assign w_sb    = op_b_signed(w_op) & i_b[W-1];
  assign w_mag_a = w_sa ? -i_a : i_a;
  assign w_mag_b = w_sb ? -i_b : i_b;

  // Multiply: {r_hi,r_lo} shifts right, r_lo starts as the multiplier.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  assign w_shift = {r_hi, r_lo[W-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    if (op_is_div(r_op)) begin
      // Remainder stays below the divisor, so w_diff[W] is a valid sign bit.
      if (!w_diff[W]) begin
        w_hi_n = w_diff[W-1:0];
        w_lo_n = {r_lo[W-2:0], 1'b1};
      end else begin
        w_hi_n = w_shift[W-1:0];
        w_lo_n = {r_lo[W-2:0], 1'b0};
      end
    end else begin
      w_hi_n = w_sum[W:1];
      w_lo_n = {w_sum[0], r_lo[W-1:1]};
    end
  end

  // Negation spans the full product before a half is picked.
  assign w_prod   = {w_hi_n, w_lo_n};
  assign w_prod_s = r_neg_main ? -w_prod : w_prod;
  assign w_quo    = r_neg_main ? -w_lo_n : w_lo_n;
  assign w_rem    = r_neg_rem ? -w_hi_n : w_hi_n;

  always_comb begin
    w_final = '0;
    unique case (r_op)
      OpMul:                     w_final = w_prod_s[W-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_final = w_prod_s[2*W-1:W];
      OpDiv, OpDivu:             w_final = w_quo;
      OpRem, OpRemu:             w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= OpMul;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_result   <= '0;
    end else if (i_load) begin
      r_op       <= w_op;
      r_neg_main <= w_sa ^ w_sb;
      r_neg_rem  <= w_sa;
      r_hi       <= '0;
      if (op_is_div(w_op)) begin
        r_lo <= w_mag_a;
        r_b  <= w_mag_b;
      end else begin
        r_lo <= w_mag_b;
        r_b  <= w_mag_a;
      end
      if (i_special) begin
        r_result <= i_special_res;
      end
    end else if (i_step) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (i_finish) begin
        r_result <= w_final;
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit for the EX stage.
// Normal ops take 32 iterations (valid_o at k+33); divide-by-zero and signed
// overflow resolve directly (valid_o at k+1).
// Ports:
//   clk, rst                 : clock, async active-high reset
//   start_i, op_i            : request and funct3, sampled only in IDLE
//   operand_a_i, operand_b_i : rs1 / rs2 values
//   flush_i                  : abort, return to IDLE
//   stall_o                  : hold IF/ID/EX while the op is accepted or running
//   busy_o                   : iterating
//   valid_o, result_o        : one-cycle result pulse, registered result
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam logic [DATA_WIDTH-1:0] MinSigned = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state_e           r_state, w_state_d;
  logic [MULDIV_CNT_W-1:0] r_cnt;
  muldiv_op_e              w_op;
  logic                    w_latch, w_load, w_step, w_finish;
  logic                    w_b_zero, w_ovf, w_special;
  logic [DATA_WIDTH-1:0]   w_special_res;

  assign w_op     = muldiv_op_e'(op_i);
  assign w_latch  = (r_state == StIdle) & start_i & ~flush_i;
  assign w_b_zero = (operand_b_i == '0);
  assign w_ovf    = (w_op inside {OpDiv, OpRem}) & (operand_a_i == MinSigned) &
                    (operand_b_i == '1);
  assign w_special = op_is_div(w_op) & (w_b_zero | w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = (w_op inside {OpDiv, OpDivu}) ? '1 : operand_a_i;
    end else if (w_op == OpDiv) begin
      w_special_res = MinSigned;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_finish  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_latch) begin
          w_load    = 1'b1;
          w_state_d = w_special ? StDone : StCalc;
        end
      end
      StCalc: begin
        w_step = 1'b1;
        if (r_cnt == MULDIV_CNT_W'(MULDIV_ITERS - 1)) begin
          // Suppressed on flush so result_o keeps its previous value.
          w_finish  = ~flush_i;
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (flush_i) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_cnt <= '0;
      end else if (r_state == StCalc) begin
        r_cnt <= r_cnt + MULDIV_CNT_W'(1);
      end
    end
  end

  assign busy_o  = (r_state == StCalc);
  assign valid_o = (r_state == StDone);
  assign stall_o = w_latch | busy_o;

  muldiv_iter_dp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_dp (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_finish     (w_finish),
    .i_special    (w_special),
    .i_special_res(w_special_res),
    .i_op         (op_i),
    .i_a          (operand_a_i),
    .i_b          (operand_b_i),
    .o_result     (result_o)
  );

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: DATA_WIDTH, default `DATA_WIDTH (32), operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  EX-stage M-extension instruction present; sampled only in IDLE.
REQ-005 op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 operand_a_i  input  DATA_WIDTH  forwarded rs1 value.
REQ-007 operand_b_i  input  DATA_WIDTH  forwarded rs2 value.
REQ-008 flush_i  input  1  EX flush from branch/jump redirect.
REQ-009 stall_o  output  1  holds IF/ID/EX pipeline registers.
REQ-010 busy_o  output  1  high while state is CALC.
REQ-011 valid_o  output  1  one-cycle pulse; result_o is valid.
REQ-012 result_o  output  DATA_WIDTH  registered result; holds its last value when valid_o is low.

Function
REQ-013 FSM SHALL have states IDLE, CALC, DONE.
REQ-014 IDLE with start_i=1 and flush_i=0 SHALL latch op and operands at the rising edge k.
REQ-015 After the IDLE latch at edge k, a normal operation SHALL go to CALC with counter=0.
REQ-016 After the IDLE latch at edge k, a special case (REQ-021/022) SHALL go directly to DONE.
REQ-017 CALC SHALL perform one radix-2 iteration per cycle and use a 5-bit counter; at counter=31 the FSM SHALL go to DONE.
REQ-018 DONE SHALL assert valid_o for exactly one cycle, then go to IDLE unconditionally; start_i SHALL be ignored in DONE.
REQ-019 Latency: valid_o SHALL be high in cycle k+33 for normal operations and in cycle k+1 for special cases.
REQ-020 stall_o SHALL be combinational: (state==IDLE & start_i & ~flush_i) | state==CALC; it SHALL be low in DONE so the instruction retires with result_o.
REQ-021 Divide by zero: DIV/DIVU SHALL return all ones; REM/REMU SHALL return the dividend.
REQ-022 Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-023 Signed operands SHALL be converted to magnitudes before the unsigned iteration.
REQ-024 MULH/MULHSU product sign SHALL be sign(a) XOR sign(b); MULHSU SHALL treat b as unsigned.
REQ-025 Quotient sign SHALL be sign(a) XOR sign(b); remainder sign SHALL follow the dividend.
REQ-026 Multiplies SHALL form a 2*DATA_WIDTH product; MUL SHALL return the low half, MULH/MULHSU/MULHU the high half.
REQ-027 Final negation SHALL be two's complement over the full product width before the half is selected.
REQ-028 flush_i=1 in any state SHALL force IDLE at the next edge with no valid_o; in IDLE with start_i=1, flush_i SHALL win.
REQ-029 start_i while in CALC SHALL be ignored; the latched operands SHALL not change.

Reset
REQ-030 rst=1 SHALL immediately drive state=IDLE, counter=0, valid_o=0, busy_o=0, result_o=0; stall_o SHALL then follow REQ-020.
REQ-031 rst asserted mid-CALC SHALL abort the operation; no valid_o SHALL follow reset release.

Structure
REQ-032 A shared package SHALL hold muldiv_op_e (funct3 encodings), muldiv_state_e, and the MULDIV_ITERS=32 constant.
REQ-033 The FSM and counter SHALL live in muldiv_seq.
REQ-034 The shift-add/restoring-subtract datapath SHALL be one sub-module, muldiv_iter_dp, controlled by load/step/finish strobes.

Verification
REQ-035 MUL 7 * 0xFFFFFFFD (-3), start at edge k -> stall_o high k..k+32, valid_o at k+33, result_o 0xFFFFFFEB.
REQ-036 MULHU 0xFFFFFFFF * 0xFFFFFFFF -> result_o 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at k+1; REM same operands -> 0; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5, each with valid_o at k+1.
REQ-038 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-039 Flush: flush_i pulsed in cycle k+10 of a DIVU -> IDLE at next edge, busy_o low, no valid_o; the next start is accepted normally.
REQ-040 Reset: rst asserted asynchronously mid-CALC -> outputs reach REQ-030 values before the next clk edge; a subsequent MUL 3*4 returns 12.
